capp_match_resolver: RTL
========================

CAPP_MATCH_RESOLVER -- requirements
Module: capp_match_resolver

Interface
REQ-001 SHALL have parameter WORDS, default 100, number of cell words / match lines.
REQ-002 SHALL have parameter WIDTH, default 32, bits per word.
REQ-003 SHALL have parameter SETTLE, default 1 (range 1..15), cycles mismatch lines are held before match lines are sampled.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1, search request.
REQ-007 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port comparand, input, WIDTH, search key.
REQ-009 SHALL have port mask, input, WIDTH, 1 = bit participates in compare.
REQ-010 SHALL have port mismatch_lines, output, 2*WIDTH, drive to the cell array; [2j] flags stored-0, [2j+1] flags stored-1.
REQ-011 SHALL have port match_lines, input, WORDS, from the cell array; 1 = word mismatched, 0 = responder.
REQ-012 SHALL have port resp_valid, output, 1, responder address valid.
REQ-013 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-014 SHALL have port resp_addr, output, clog2(WORDS), responder index.
REQ-015 SHALL have port resp_last, output, 1, final response of current search.
REQ-016 SHALL have port resp_none, output, 1, search had zero responders.
REQ-017 SHALL have port match_count, output, clog2(WORDS+1), responder count of last search.

Function
REQ-018 SHALL implement FSM states IDLE, DRIVE, CAPTURE, EMIT.
REQ-019 SHALL accept a command on cmd_valid&&cmd_ready, registering comparand and mask, and go IDLE->DRIVE.
REQ-020 SHALL, for bit j with mask[j]=1, drive mismatch_lines[2j]=comparand[j] and [2j+1]=~comparand[j]; with mask[j]=0, drive both 0.
REQ-021 SHALL drive mismatch_lines all-zero in IDLE and EMIT, and from registered values in DRIVE and CAPTURE.
REQ-022 SHALL stay in DRIVE exactly SETTLE cycles via a down-counter, then enter CAPTURE.
REQ-023 SHALL in CAPTURE latch responder vector R = ~match_lines and match_count = popcount(R), then enter EMIT next cycle.
REQ-024 SHALL in EMIT present resp_addr = lowest set index of R with resp_valid=1 and resp_last=1 iff exactly one bit of R is set.
REQ-025 SHALL on resp_valid&&resp_ready clear that bit of R; if it was last, return to IDLE; else present next-lowest index the following cycle.
REQ-026 SHALL, when R is all-zero at EMIT entry, issue one response with resp_none=1, resp_last=1, resp_addr=0, then return to IDLE on handshake.
REQ-027 SHALL hold resp_addr, resp_last, resp_none stable while resp_valid=1 and resp_ready=0.
REQ-028 SHALL give latency: command accepted at edge T -> resp_valid first high after edge T+SETTLE+2.
REQ-029 SHALL ignore cmd_valid outside IDLE; a cmd_valid arriving in the cycle of the final handshake is accepted only on the following IDLE cycle.
REQ-030 SHALL sustain one response per cycle with resp_ready held high.
REQ-031 SHALL keep match_count stable from CAPTURE until the next CAPTURE.

Reset
REQ-032 SHALL on rst_n low, immediately and asynchronously, force IDLE, cmd_ready=1, resp_valid=0, resp_last=0, resp_none=0, resp_addr=0, match_count=0, mismatch_lines=0, R=0.
REQ-033 SHALL abandon any in-progress search on mid-operation reset with no response issued for it after release.

Verification
REQ-034 SHALL cover: array words 0..4 = 456,457,1000,1000,457, word k=k for 5..98, word 99=457; search 457 mask FFFFFFFF -> resp_addr 1,4,99, resp_last only on 99, match_count=3.
REQ-035 SHALL cover: search 12345 mask FFFFFFFF -> single response resp_none=1, resp_last=1, resp_addr=0, match_count=0.
REQ-036 SHALL cover: mask 0 -> mismatch_lines all-zero during DRIVE, responses 0..99 back-to-back with resp_ready=1, match_count=100, resp_last on 99.
REQ-037 SHALL cover: search 1000 with resp_ready low 3 cycles -> resp_addr held at 2 for those cycles, then 3 with resp_last=1.
REQ-038 SHALL cover: rst_n pulsed low while in EMIT after first response -> outputs at reset values at once, cmd_ready=1 after release, no further responses.
REQ-039 SHALL cover: SETTLE=3, comparand 0x1 mask 0x1 -> mismatch_lines=0x1 for 4 cycles (DRIVE+CAPTURE), first resp_valid 5 cycles after accept.

Source files
------------

// File: rtl/capp_match_resolver.sv
// Associative-processor match resolver.
// Drives the compare (mismatch) lines of a content-addressable cell array.
// After a programmable settle time it samples the per-word match lines.
// It then walks the responders lowest-address-first over a valid/ready channel.

// Per-bit compare-line driver.
// A masked-in bit pulls the line of the opposite stored value,
// so any word holding a different bit discharges its match line.
// [0] flags a stored 0 (driven by comparand=1), [1] flags a stored 1.
module capp_ml_drv (
  input  logic       en,
  input  logic       cmp_bit,
  input  logic       msk_bit,
  output logic [1:0] ml
);
  assign ml = (en && msk_bit) ? {~cmp_bit, cmp_bit} : 2'b00;
endmodule

module capp_match_resolver #(
  parameter int WORDS  = 100,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1,
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int CW    = $clog2(WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     comparand,
  input  logic [WIDTH-1:0]     mask,
  output logic [2*WIDTH-1:0]   mismatch_lines,
  input  logic [WORDS-1:0]     match_lines,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [AW-1:0]        resp_addr,
  output logic                 resp_last,
  output logic                 resp_none,
  output logic [CW-1:0]        match_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, EMIT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] comparand;
    logic [WIDTH-1:0] mask;
  } cmd_t;

  state_t           state, state_nx;
  cmd_t             cmd_q;
  logic [3:0]       settle_cnt;
  logic [WORDS-1:0] resp_vec;     // outstanding responders, current one included
  logic             drv_en;

  assign cmd_ready = (state == IDLE);
  assign drv_en    = (state == DRIVE) || (state == CAPTURE);

  // One compare-line driver per key bit; lines stay low outside DRIVE/CAPTURE.
  for (genvar j = 0; j < WIDTH; j++) begin : g_drv
    capp_ml_drv u_drv (
      .en      (drv_en),
      .cmp_bit (cmd_q.comparand[j]),
      .msk_bit (cmd_q.mask[j]),
      .ml      (mismatch_lines[2*j +: 2])
    );
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = DRIVE;
      DRIVE:   if (settle_cnt == 4'd0) state_nx = CAPTURE;
      CAPTURE: state_nx = EMIT;
      EMIT:    if (resp_valid && resp_ready && resp_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, command capture and settle down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        cmd_q.comparand <= comparand;
        cmd_q.mask      <= mask;
        settle_cnt      <= 4'(SETTLE - 1);
      end else if (state == DRIVE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  // Responder count of the array as currently seen (match line low = responder).
  logic [CW-1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WORDS; i++) pop = pop + CW'(!match_lines[i]);
  end

  // Next responder selection.
  // While a response is showing, look past it (it leaves on handshake);
  // before the first response, look at the whole captured vector.
  logic [WORDS-1:0] addr_oh, lo_oh, src_vec, rest_vec;
  logic [AW-1:0]    lo_addr;
  logic             src_any;
  always_comb begin
    addr_oh = '0;
    for (int i = 0; i < WORDS; i++) addr_oh[i] = (resp_addr == AW'(i));
    src_vec = resp_valid ? (resp_vec & ~addr_oh) : resp_vec;
    lo_addr = '0;
    lo_oh   = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (src_vec[i]) begin
        lo_addr = AW'(i);
        lo_oh   = '0;
        lo_oh[i] = 1'b1;
      end
    end
    rest_vec = src_vec & ~lo_oh;
    src_any  = |src_vec;
  end

  // Capture responders, then present them one per handshake, lowest first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vec    <= '0;
      match_count <= '0;
      resp_valid  <= 1'b0;
      resp_addr   <= '0;
      resp_last   <= 1'b0;
      resp_none   <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          resp_vec    <= ~match_lines;
          match_count <= pop;
        end
        EMIT: begin
          if (!resp_valid) begin
            // first response; an empty vector yields the single "none" beat
            resp_valid <= 1'b1;
            resp_addr  <= lo_addr;
            resp_last  <= ~|rest_vec;
            resp_none  <= ~src_any;
          end else if (resp_ready) begin
            resp_vec <= src_vec;
            if (resp_last) begin
              resp_valid <= 1'b0;
              resp_addr  <= '0;
              resp_last  <= 1'b0;
              resp_none  <= 1'b0;
            end else begin
              resp_addr <= lo_addr;
              resp_last <= ~|rest_vec;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
